// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: operation encoding and
// elaboration-time block/stage index arithmetic.
package csel_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

   function automatic int unsigned blk_lo(input int unsigned k, input int unsigned blk);
      return k * blk;
   endfunction

   // Last block may be narrower than blk.
   function automatic int unsigned blk_hi(input int unsigned k, input int unsigned blk,
                                          input int unsigned width);
      return (((k + 1) * blk) < width) ? ((k + 1) * blk - 1) : (width - 1);
   endfunction

   function automatic int unsigned stg_first(input int unsigned s, input int unsigned bps);
      return s * bps;
   endfunction

   function automatic int unsigned stg_last(input int unsigned s, input int unsigned bps,
                                            input int unsigned nb);
      return (((s + 1) * bps) < nb) ? ((s + 1) * bps - 1) : (nb - 1);
   endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: both carry-in outcomes are summed up front and the
// real incoming carry only drives the final mux.
module csel_block
   import csel_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] r0;
   logic [W:0] r1;

   always_comb begin
      r0      = (W+1)'(a) + (W+1)'(b);
      r1      = (W+1)'(a) + (W+1)'(b) + (W+1)'(1);
      {co, s} = ci ? r1 : r0;
   end

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: slices grouped into register ranks,
// valid/ready handshake with a global stall that freezes every rank.
module pipelined_csel_adder
   import csel_pkg::*;
#(
   parameter int unsigned WIDTH  = 19,
   parameter int unsigned BLOCK  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NB   = ceil_div(WIDTH, (BLOCK == 0) ? 1 : BLOCK);
   localparam int unsigned BPS  = ceil_div(NB, (STAGES == 0) ? 1 : STAGES);
   localparam int unsigned LAST = STAGES - 1;

   if (WIDTH < 2 || BLOCK < 1 || BLOCK > WIDTH || STAGES < 1 || (STAGES - 1) * BPS >= NB)
   begin : g_bad_cfg
      $error("pipelined_csel_adder: illegal WIDTH/BLOCK/STAGES (empty stage or bad width)");
   end

   op_e              op;
   logic             en;

   // Per-stage combinational view: what enters the stage and what it produces.
   logic [WIDTH-1:0] a_in   [STAGES];
   logic [WIDTH-1:0] b_in   [STAGES];
   logic [WIDTH-1:0] sum_in [STAGES];
   logic             c_in   [STAGES];
   logic             v_in   [STAGES];
   logic [WIDTH-1:0] sum_nx [STAGES];
   logic             c_nx   [STAGES];

   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             c_q     [STAGES];
   logic             c_d     [STAGES];
   logic             ovf_q;
   logic             ovf_d;

   assign op = op_e'(sub);

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int unsigned FB = stg_first(s, BPS);
      localparam int unsigned LB = stg_last(s, BPS, NB);

      if (s == 0) begin : g_head
         assign a_in[0]   = a;
         assign b_in[0]   = b ^ {WIDTH{op == OP_SUB}};
         assign c_in[0]   = cin ^ (op == OP_SUB);
         assign sum_in[0] = '0;
         assign v_in[0]   = in_valid;
      end else begin : g_link
         assign a_in[s]   = a_q[s-1];
         assign b_in[s]   = b_q[s-1];
         assign c_in[s]   = c_q[s-1];
         assign sum_in[s] = sum_q[s-1];
         assign v_in[s]   = valid_q[s-1];
      end

      // Each slice overlays its bits onto the running sum handed on by its predecessor.
      for (genvar k = FB; k <= LB; k++) begin : g_blk
         localparam int unsigned BL = blk_lo(k, BLOCK);
         localparam int unsigned BH = blk_hi(k, BLOCK, WIDTH);

         logic             ci;
         logic             co;
         logic [BH-BL:0]   s_blk;
         logic [WIDTH-1:0] acc_prev;
         logic [WIDTH-1:0] acc;

         if (k == FB) begin : g_first
            assign ci       = c_in[s];
            assign acc_prev = sum_in[s];
         end else begin : g_chain
            assign ci       = g_blk[k-1].co;
            assign acc_prev = g_blk[k-1].acc;
         end

         csel_block #(.W(BH - BL + 1)) u_blk (
            .a  (a_in[s][BH:BL]),
            .b  (b_in[s][BH:BL]),
            .ci (ci),
            .s  (s_blk),
            .co (co)
         );

         always_comb begin
            acc        = acc_prev;
            acc[BH:BL] = s_blk;
         end
      end

      assign sum_nx[s] = g_blk[LB].acc;
      assign c_nx[s]   = g_blk[LB].co;
   end

   // Global stall: every rank holds while the last rank is blocked downstream.
   always_comb begin
      en = !valid_q[LAST] || out_ready;
      for (int s = 0; s < STAGES; s++) begin
         valid_d[s] = valid_q[s];
         a_d[s]     = a_q[s];
         b_d[s]     = b_q[s];
         sum_d[s]   = sum_q[s];
         c_d[s]     = c_q[s];
         if (en) begin
            valid_d[s] = v_in[s];
            a_d[s]     = a_in[s];
            b_d[s]     = b_in[s];
            sum_d[s]   = sum_nx[s];
            c_d[s]     = c_nx[s];
         end
      end
      ovf_d = ovf_q;
      if (en) begin
         ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                 (sum_nx[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            valid_q[s] <= 1'b0;
            a_q[s]     <= '0;
            b_q[s]     <= '0;
            sum_q[s]   <= '0;
            c_q[s]     <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            valid_q[s] <= valid_d[s];
            a_q[s]     <= a_d[s];
            b_q[s]     <= b_d[s];
            sum_q[s]   <= sum_d[s];
            c_q[s]     <= c_d[s];
         end
         ovf_q <= ovf_d;
      end
   end

   assign in_ready  = en;
   assign out_valid = valid_q[LAST];
   assign sum       = sum_q[LAST];
   assign cout      = c_q[LAST];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench: directed vectors on the default configuration plus random
// streams with random handshakes on several width/block/stage configurations.
module tb_pipelined_csel_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [18:0] a;
   logic [18:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [18:0] sum;
   logic        cout;
   logic        ovf;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipelined_csel_adder #(.WIDTH(19), .BLOCK(4), .STAGES(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Independent reference: packs {ovf, cout, sum} with sum in the low w bits.
   function automatic logic [63:0] golden(input int unsigned w, input logic [63:0] x,
                                          input logic [63:0] y, input logic ci, input logic sb);
      logic [63:0] mask;
      logic [63:0] be;
      logic [63:0] s;
      logic [64:0] t;
      logic        co;
      logic        ov;
      mask = (64'd1 << w) - 64'd1;
      be   = (y ^ {64{sb}}) & mask;
      t    = 65'(x & mask) + 65'(be) + 65'(ci ^ sb);
      s    = t[63:0] & mask;
      co   = t[w];
      ov   = (x[w-1] == be[w-1]) && (s[w-1] != x[w-1]);
      return s | (64'(co) << w) | (64'(ov) << (w + 1));
   endfunction

   task automatic send(input logic [18:0] ta, input logic [18:0] tb, input logic tc,
                       input logic ts, input logic [63:0] req);
      int n = 0;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("accept", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(req);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic stall_proc();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("bp_first_result", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_valid_held", 64'(out_valid), 64'd1);
         chk("bp_data_held", 64'({ovf, cout, sum}), 64'h202);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
   endtask

   // Monitor: retire one expected result per output handshake.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dut_unexpected_beat actual=%0h required=no_output", {ovf, cout, sum});
         end else begin
            chk("dut_result", 64'({ovf, cout, sum}), exp_q.pop_front());
         end
      end
   end

   // 32/8/3 would leave the third rank empty, so the wide case uses 6-bit slices.
   for (genvar g = 0; g < 4; g++) begin : g_rnd
      localparam int unsigned W  = (g == 3) ? 32 : 19;
      localparam int unsigned BK = (g == 3) ? 6 : 4;
      localparam int unsigned ST = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 3;

      logic         rs;
      logic         iv;
      logic         ir;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         ci;
      logic         sb;
      logic         ov;
      logic         orr;
      logic [W-1:0] s;
      logic         co;
      logic         of;
      logic         done;
      logic [63:0]  q[$];

      pipelined_csel_adder #(.WIDTH(W), .BLOCK(BK), .STAGES(ST)) u_dut (
         .clk       (clk),
         .rst       (rs),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (ra),
         .b         (rb),
         .cin       (ci),
         .sub       (sb),
         .out_valid (ov),
         .out_ready (orr),
         .sum       (s),
         .cout      (co),
         .ovf       (of)
      );

      initial begin : drv
         int sent;
         int guard;
         done = 1'b0; rs = 1'b1; iv = 1'b0; orr = 1'b1;
         ra = '0; rb = '0; ci = 1'b0; sb = 1'b0;
         sent = 0; guard = 0;
         repeat (2) @(posedge clk);
         #1 rs = 1'b0;
         while (sent < 1000 && guard < 20000) begin
            guard++;
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            ra  = W'($urandom);
            rb  = W'($urandom);
            ci  = 1'($urandom);
            sb  = 1'($urandom);
            @(negedge clk);
            if (iv && ir) begin
               q.push_back(golden(W, 64'(ra), 64'(rb), ci, sb));
               sent++;
            end
            @(posedge clk);
            #1;
         end
         iv = 1'b0; orr = 1'b1;
         repeat (ST + 4) @(negedge clk);
         chk($sformatf("rnd%0d_sent", g), 64'(sent), 64'd1000);
         chk($sformatf("rnd%0d_drain", g), 64'(q.size()), 64'd0);
         done = 1'b1;
      end

      always @(negedge clk) begin
         if (rs) begin
            q.delete();
         end else if (ov && orr) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rnd%0d_unexpected_beat actual=%0h required=no_output", g, {of, co, s});
            end else begin
               chk($sformatf("rnd%0d_result", g), 64'({of, co, s}), q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      logic all_done;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      a = 19'h12345; b = 19'h00ABC; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_quiet", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;

      // Carry ripples through every slice and both ranks.
      send(19'h7FFFF, 19'h00000, 1'b1, 1'b0, 64'h80000);
      @(negedge clk);
      chk("latency_n1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("latency_n2", 64'(out_valid), 64'd1);
      drain();

      send(19'h00005, 19'h00007, 1'b0, 1'b1, 64'h7FFFE);
      send(19'h3FFFF, 19'h00001, 1'b0, 1'b0, 64'h140000);
      send(19'h0000A, 19'h00003, 1'b1, 1'b1, 64'h80006);
      send(19'h40000, 19'h00001, 1'b0, 1'b1, 64'h1BFFFF);
      drain();

      fork
         begin
            for (int k = 1; k <= 4; k++)
               send(19'(k * 256), 19'(k), 1'b0, 1'b0, 64'(k * 257));
         end
         stall_proc();
      join
      drain();

      send(19'h11111, 19'h22222, 1'b0, 1'b0, 64'h33333);
      send(19'h00001, 19'h00002, 1'b0, 1'b1, 64'h7FFFF);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_rst_discard", 64'(out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      send(19'h2AAAA, 19'h15555, 1'b0, 1'b0, 64'h3FFFF);
      drain();

      n = 0;
      all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done;
      while (!all_done && n < 40000) begin
         n++;
         @(posedge clk);
         all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done;
      end
      chk("rnd_complete", 64'(all_done), 64'd1);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
